// File: rtl/coef_loader.sv
// coef_loader: serial coefficient loader with a bounded, combinational read port for the node timer
module coef_loader #(
  parameter int NUM_COEF = 64,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic [IDX_W-1:0]  max_input,
  input  logic [DATA_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_req,
  output logic              coef_ready,
  input  logic              n_start_done,
  input  logic [IDX_W-1:0]  input_num,
  output logic [DATA_W-1:0] coef_out,
  output logic              load_err
);
  localparam logic [IDX_W-1:0] MAXC = IDX_W'(NUM_COEF);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  state_t             state_q;
  logic [IDX_W-1:0]   cnt_q, wptr_q, rd_idx_d;
  logic [DATA_W-1:0]  mem_q [NUM_COEF+1];
  logic               req_q, ready_q, err_q;
  // entry 0 is never written, so any out-of-window index folds onto it and reads 0
  always_comb begin
    rd_idx_d = (input_num <= cnt_q) ? input_num : '0;
    coef_out = mem_q[rd_idx_d];
  end
  assign coef_req   = req_q;
  assign coef_ready = ready_q;
  assign load_err   = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i <= NUM_COEF; i++) mem_q[i] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (start_load) begin
          if (max_input != '0 && max_input <= MAXC) begin
            cnt_q   <= max_input;
            wptr_q  <= IDX_W'(1);
            req_q   <= 1'b1;
            state_q <= LOAD;
          end else err_q <= 1'b1;
        end
        LOAD: if (coef_valid && req_q) begin
          mem_q[wptr_q] <= coef_in;
          wptr_q        <= wptr_q + 1'b1;
          if (wptr_q == cnt_q) begin
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= READY;
          end
        end
        READY: if (n_start_done) begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coef_loader.sv
// tb_coef_loader: directed plus random stimulus against a beat-counting reference model
`timescale 1ns/10ps
module tb_coef_loader;
  logic        clk, rst, start_load, coef_valid, n_start_done;
  logic [6:0]  max_input, input_num;
  logic [15:0] coef_in, coef_out;
  logic        coef_req, coef_ready, load_err;
  int total = 0, bad = 0;
  logic [15:0] m [128];
  int cnt, rem, nxt;
  bit rdy, err;
  coef_loader dut (
    .clk(clk), .rst(rst), .start_load(start_load), .max_input(max_input),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_req(coef_req),
    .coef_ready(coef_ready), .n_start_done(n_start_done), .input_num(input_num),
    .coef_out(coef_out), .load_err(load_err)
  );
  initial clk = 0;
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_out(input int i);
    return (i >= 1 && i <= cnt) ? m[i] : 16'h0;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 128; i++) m[i] = '0;
    cnt = 0; rem = 0; nxt = 0; rdy = 0; err = 0;
  endtask
  task automatic model_edge();
    err = 0;
    if (rem > 0) begin
      if (coef_valid) begin
        m[nxt] = coef_in; nxt++; rem--;
        if (rem == 0) rdy = 1;
      end
    end else if (rdy) begin
      if (n_start_done) rdy = 0;
    end else if (start_load) begin
      if (max_input >= 1 && max_input <= 64) begin
        cnt = max_input; nxt = 1; rem = max_input;
      end else err = 1;
    end
  endtask
  task automatic check_outs();
    chk("coef_req", 32'(coef_req), 32'(rem > 0));
    chk("coef_ready", 32'(coef_ready), 32'(rdy));
    chk("load_err", 32'(load_err), 32'(err));
    chk("coef_out", 32'(coef_out), 32'(exp_out(int'(input_num))));
  endtask
  task automatic sweep();
    for (int i = 0; i < 128; i++) begin
      input_num = 7'(i);
      #0.01;
      chk("sweep", 32'(coef_out), 32'(exp_out(i)));
    end
  endtask
  task automatic step(input bit sl, input logic [6:0] mx, input bit v, input logic [15:0] d, input bit nsd);
    start_load = sl; max_input = mx; coef_valid = v; coef_in = d; n_start_done = nsd;
    input_num = 7'($urandom_range(0, 127));
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 7'd0, 0, 16'h0, 0);
  endtask
  task automatic mid_reset();
    #3 rst = 1;
    model_reset();
    #1;
    chk("rst_req", 32'(coef_req), 32'd0);
    chk("rst_ready", 32'(coef_ready), 32'd0);
    sweep();
    #4 rst = 0;
  endtask
  initial begin
    rst = 1; start_load = 0; max_input = 0; coef_valid = 0; coef_in = 0;
    n_start_done = 0; input_num = 0;
    model_reset();
    #25 rst = 0;
    idle(5);
    sweep();
    step(1, 7'd4, 0, 16'h0, 0);
    step(0, 7'd0, 1, 16'h0011, 0);
    step(0, 7'd0, 1, 16'h0022, 0);
    step(0, 7'd0, 1, 16'h0033, 0);
    step(0, 7'd0, 1, 16'h0044, 0);
    idle(2);
    sweep();
    step(0, 7'd0, 0, 16'h0, 1);
    step(1, 7'd3, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 7'd0, (i % 2) == 0, 16'(16'h0100 + i), 0);
    idle(1);
    sweep();
    step(1, 7'd5, 0, 16'h0, 0);
    chk("ready_ignores_start", 32'(coef_req), 32'd0);
    step(0, 7'd0, 0, 16'h0, 1);
    step(1, 7'd0, 0, 16'h0, 0);
    step(0, 7'd0, 0, 16'h0, 0);
    step(1, 7'd65, 0, 16'h0, 0);
    idle(2);
    step(1, 7'd2, 0, 16'h0, 0);
    step(0, 7'd0, 1, 16'hAAAA, 0);
    step(1, 7'd9, 1, 16'hBBBB, 0);
    idle(1);
    sweep();
    step(1, 7'd2, 0, 16'h0, 1);
    idle(2);
    step(1, 7'd4, 0, 16'h0, 0);
    step(0, 7'd0, 1, 16'h1234, 0);
    coef_valid = 1; coef_in = 16'h5678;
    mid_reset();
    idle(1);
    step(1, 7'd4, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 7'd0, 1, 16'(16'hC000 + i), 0);
    idle(1);
    sweep();
    step(0, 7'd0, 0, 16'h0, 1);
    for (int c = 0; c < 3000; c++) begin
      logic [6:0] mx;
      int r;
      r = $urandom_range(0, 19);
      mx = (r == 0) ? 7'd0 : (r == 1) ? 7'd64 : (r == 2) ? 7'd65 : (r == 3) ? 7'($urandom_range(65, 127)) : 7'($urandom_range(1, 12));
      if ($urandom_range(0, 299) == 0) begin
        coef_valid = 1'($urandom); coef_in = 16'($urandom);
        mid_reset();
      end
      step($urandom_range(0, 3) == 0, mx, 1'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
      if ((c % 500) == 499) sweep();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
